// File: rtl/sort_stream_checker.sv
// sort_stream_checker: per-packet framing, order, length and sum checker on a sorted stream.
module sort_stream_checker #(
    parameter int DATA_WIDTH = 16,
    parameter int MAX_LENGTH = 256,
    localparam int LEN_WIDTH = $clog2(MAX_LENGTH) + 1,
    localparam int SUM_WIDTH = DATA_WIDTH + LEN_WIDTH
) (
    input  logic                  snk_clock,
    input  logic                  snk_reset,
    input  logic [DATA_WIDTH-1:0] snk_data,
    input  logic                  snk_sop,
    input  logic                  snk_eop,
    input  logic                  snk_valid,
    input  logic [LEN_WIDTH-1:0]  exp_len,
    input  logic [SUM_WIDTH-1:0]  exp_sum,
    output logic                  chk_done,
    output logic                  chk_pass,
    output logic                  chk_err_order,
    output logic                  chk_err_frame,
    output logic                  chk_err_len,
    output logic                  chk_err_sum,
    output logic [LEN_WIDTH-1:0]  pkt_len,
    output logic [15:0]           pkt_count,
    output logic [15:0]           err_count
);
    typedef enum logic {IDLE, PKT} state_t;

    state_t                state_q, state_d;
    logic                  pend_q, pend_d;
    logic [DATA_WIDTH-1:0] prev_q, prev_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d, elen_q, elen_d, plen_q, plen_d;
    logic [SUM_WIDTH-1:0]  sum_q, sum_d, esum_q, esum_d;
    logic                  ord_q, ord_d, ovf_q, ovf_d;
    logic                  done_q, done_d, pass_q, pass_d;
    logic                  eord_q, eord_d, efrm_q, efrm_d, elerr_q, elerr_d, eserr_q, eserr_d;
    logic [15:0]           pcnt_q, pcnt_d, ecnt_q, ecnt_d;

    logic                  a_max, a_ord, a_ovf, ld, apply, cl, use_a, use_n, frame, orphan;
    logic [LEN_WIDTH-1:0]  a_len, c_len, c_elen;
    logic [SUM_WIDTH-1:0]  a_sum, c_sum, c_esum;
    logic                  c_ord, c_ovf, c_elerr, c_serr, c_fail;
    logic [1:0]            einc;
    logic [16:0]           ecnt_sum;

    always_comb begin
        a_max   = len_q == LEN_WIDTH'(MAX_LENGTH);
        a_len   = a_max ? len_q : len_q + 1'b1;
        a_sum   = sum_q + SUM_WIDTH'(snk_data);
        a_ord   = ord_q | (snk_data < prev_q);
        a_ovf   = ovf_q | a_max;
        state_d = state_q;
        pend_d  = 1'b0;
        ld      = 1'b0;
        apply   = 1'b0;
        cl      = 1'b0;
        use_a   = 1'b0;
        use_n   = 1'b0;
        frame   = 1'b0;
        orphan  = 1'b0;
        if (snk_valid) begin
            if (state_q == PKT && !snk_sop) begin
                apply = 1'b1;
                use_a = 1'b1;
                cl    = snk_eop;
                if (snk_eop) state_d = IDLE;
            end else if (snk_sop) begin
                ld      = 1'b1;
                state_d = snk_eop ? IDLE : PKT;
                // A stored packet closes now; a single-beat new packet is deferred one cycle.
                if (state_q == PKT || pend_q) begin
                    cl     = 1'b1;
                    frame  = state_q == PKT;
                    pend_d = snk_eop;
                end else begin
                    cl    = snk_eop;
                    use_n = 1'b1;
                end
            end else begin
                orphan = 1'b1;
            end
        end
        if (pend_q && !cl) cl = 1'b1;
        prev_d   = (ld || apply) ? snk_data : prev_q;
        len_d    = ld ? LEN_WIDTH'(1) : apply ? a_len : len_q;
        sum_d    = ld ? SUM_WIDTH'(snk_data) : apply ? a_sum : sum_q;
        elen_d   = ld ? exp_len : elen_q;
        esum_d   = ld ? exp_sum : esum_q;
        ord_d    = ld ? 1'b0 : apply ? a_ord : ord_q;
        ovf_d    = ld ? 1'b0 : apply ? a_ovf : ovf_q;
        c_len    = use_n ? LEN_WIDTH'(1) : use_a ? a_len : len_q;
        c_elen   = use_n ? exp_len : elen_q;
        c_sum    = use_n ? SUM_WIDTH'(snk_data) : use_a ? a_sum : sum_q;
        c_esum   = use_n ? exp_sum : esum_q;
        c_ord    = use_a ? a_ord : !use_n & ord_q;
        c_ovf    = use_a ? a_ovf : !use_n & ovf_q;
        c_elerr  = c_ovf | (c_len != c_elen);
        c_serr   = c_sum != c_esum;
        c_fail   = c_ord | frame | c_elerr | c_serr;
        done_d   = cl;
        pass_d   = cl ? !c_fail : pass_q;
        eord_d   = cl ? c_ord : eord_q;
        efrm_d   = cl ? frame : efrm_q;
        elerr_d  = cl ? c_elerr : elerr_q;
        eserr_d  = cl ? c_serr : eserr_q;
        plen_d   = cl ? c_len : plen_q;
        pcnt_d   = (cl && pcnt_q != 16'hFFFF) ? pcnt_q + 1'b1 : pcnt_q;
        einc     = {1'b0, cl & c_fail} + {1'b0, orphan};
        ecnt_sum = {1'b0, ecnt_q} + 17'(einc);
        ecnt_d   = ecnt_sum[16] ? 16'hFFFF : ecnt_sum[15:0];
    end

    always_ff @(posedge snk_clock) begin
        if (snk_reset) begin
            state_q <= IDLE;
            pend_q  <= 1'b0;
            prev_q  <= '0;
            len_q   <= '0;
            sum_q   <= '0;
            elen_q  <= '0;
            esum_q  <= '0;
            ord_q   <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            eord_q  <= 1'b0;
            efrm_q  <= 1'b0;
            elerr_q <= 1'b0;
            eserr_q <= 1'b0;
            plen_q  <= '0;
            pcnt_q  <= '0;
            ecnt_q  <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            prev_q  <= prev_d;
            len_q   <= len_d;
            sum_q   <= sum_d;
            elen_q  <= elen_d;
            esum_q  <= esum_d;
            ord_q   <= ord_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            eord_q  <= eord_d;
            efrm_q  <= efrm_d;
            elerr_q <= elerr_d;
            eserr_q <= eserr_d;
            plen_q  <= plen_d;
            pcnt_q  <= pcnt_d;
            ecnt_q  <= ecnt_d;
        end
    end

    assign chk_done      = done_q;
    assign chk_pass      = pass_q;
    assign chk_err_order = eord_q;
    assign chk_err_frame = efrm_q;
    assign chk_err_len   = elerr_q;
    assign chk_err_sum   = eserr_q;
    assign pkt_len       = plen_q;
    assign pkt_count     = pcnt_q;
    assign err_count     = ecnt_q;
endmodule

// File: tb/tb_sort_stream_checker.sv
// tb_sort_stream_checker: directed and random packets against a beat-list reference model.
module tb_sort_stream_checker;
    logic        snk_clock = 1'b0;
    logic        snk_reset = 1'b1;
    logic [15:0] snk_data = '0;
    logic        snk_sop = 1'b0, snk_eop = 1'b0, snk_valid = 1'b0;
    logic [8:0]  exp_len = '0;
    logic [24:0] exp_sum = '0;
    logic        chk_done, chk_pass, chk_err_order, chk_err_frame, chk_err_len, chk_err_sum;
    logic [8:0]  pkt_len;
    logic [15:0] pkt_count, err_count;

    sort_stream_checker dut (
        .snk_clock(snk_clock), .snk_reset(snk_reset), .snk_data(snk_data),
        .snk_sop(snk_sop), .snk_eop(snk_eop), .snk_valid(snk_valid),
        .exp_len(exp_len), .exp_sum(exp_sum), .chk_done(chk_done), .chk_pass(chk_pass),
        .chk_err_order(chk_err_order), .chk_err_frame(chk_err_frame),
        .chk_err_len(chk_err_len), .chk_err_sum(chk_err_sum), .pkt_len(pkt_len),
        .pkt_count(pkt_count), .err_count(err_count)
    );

    always #5 snk_clock = ~snk_clock;

    typedef struct {bit pass; bit ord; bit frame; bit elen; bit esum; int len;} vd_t;
    vd_t sb[$];
    vd_t mv;
    int  checks = 0, failures = 0;
    bit  in_pkt = 0;
    int  beats[$];
    int  m_el, m_es, m_pkt = 0, m_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic mclose(input bit frame);
        vd_t v;
        int  s = 0;
        v.ord = 0;
        foreach (beats[i]) begin
            s += beats[i];
            if (i > 0 && beats[i] < beats[i-1]) v.ord = 1;
        end
        s = s % 33554432;
        v.len   = beats.size() > 256 ? 256 : beats.size();
        v.elen  = beats.size() > 256 || beats.size() != m_el;
        v.esum  = s != m_es;
        v.frame = frame;
        v.pass  = !(v.ord | frame | v.elen | v.esum);
        sb.push_back(v);
        if (m_pkt < 65535) m_pkt++;
        if (!v.pass && m_err < 65535) m_err++;
        in_pkt = 0;
    endtask

    task automatic mstep(input bit v, input bit s, input bit e, input int d, input int el, input int es);
        if (!v) return;
        if (s) begin
            if (in_pkt) mclose(1);
            beats.delete();
            beats.push_back(d);
            m_el = el;
            m_es = es;
            in_pkt = 1;
            if (e) mclose(0);
        end else if (in_pkt) begin
            beats.push_back(d);
            if (e) mclose(0);
        end else if (m_err < 65535) m_err++;
    endtask

    task automatic beat(input logic v, input logic s, input logic e, input logic [15:0] d,
                        input logic [8:0] el, input logic [24:0] es);
        snk_valid = v; snk_sop = s; snk_eop = e; snk_data = d; exp_len = el; exp_sum = es;
        mstep(v, s, e, int'(d), int'(el), int'(es));
        @(posedge snk_clock);
        #1;
        snk_valid = 1'b0;
    endtask

    task automatic idle();
        beat(1'b0, 1'b0, 1'b0, 16'h0, 9'h0, 25'h0);
    endtask

    task automatic do_reset();
        snk_reset = 1'b1;
        @(posedge snk_clock);
        #1;
        check("rst_done", 32'(chk_done), 0);
        check("rst_pass", 32'(chk_pass), 0);
        check("rst_errs", 32'({chk_err_order, chk_err_frame, chk_err_len, chk_err_sum}), 0);
        check("rst_len", 32'(pkt_len), 0);
        check("rst_pcnt", 32'(pkt_count), 0);
        check("rst_ecnt", 32'(err_count), 0);
        snk_reset = 1'b0;
        in_pkt = 0; beats.delete(); sb.delete(); m_pkt = 0; m_err = 0;
    endtask

    always @(negedge snk_clock) begin
        if (!snk_reset && chk_done) begin
            if (sb.size() == 0) check("spurious_done", 1, 0);
            else begin
                mv = sb.pop_front();
                check("v_pass", 32'(chk_pass), 32'(mv.pass));
                check("v_order", 32'(chk_err_order), 32'(mv.ord));
                check("v_frame", 32'(chk_err_frame), 32'(mv.frame));
                check("v_len", 32'(chk_err_len), 32'(mv.elen));
                check("v_sum", 32'(chk_err_sum), 32'(mv.esum));
                check("v_pktlen", 32'(pkt_len), 32'(mv.len));
            end
        end
    end

    initial begin
        int vals[10];
        do_reset();
        beat(1, 1, 0, 1, 4, 10); beat(1, 0, 0, 2, 0, 0); beat(1, 0, 0, 3, 0, 0);
        check("t1_nodone", 32'(chk_done), 0);
        beat(1, 0, 1, 4, 0, 0);
        check("t1_done", 32'(chk_done), 1);
        check("t1_pass", 32'(chk_pass), 1);
        check("t1_len", 32'(pkt_len), 4);
        check("t1_pcnt", 32'(pkt_count), 1);
        idle();
        check("t1_pulse", 32'(chk_done), 0);
        beat(1, 1, 0, 5, 3, 15); beat(1, 0, 0, 3, 0, 0); beat(1, 0, 1, 7, 0, 0);
        check("t2_order", 32'(chk_err_order), 1);
        check("t2_pass", 32'(chk_pass), 0);
        check("t2_ecnt", 32'(err_count), 1);
        beat(1, 1, 1, 16'hFFFF, 1, 25'hFFFF);
        check("t3_done0", 32'(chk_done), 1);
        check("t3_pass0", 32'(chk_pass), 1);
        beat(1, 1, 1, 16'hFFFF, 1, 25'hFFFF);
        check("t3_done1", 32'(chk_done), 1);
        beat(1, 1, 0, 10, 2, 30); beat(1, 0, 0, 20, 0, 0); beat(1, 1, 1, 30, 1, 30);
        check("t4_done0", 32'(chk_done), 1);
        check("t4_frame", 32'(chk_err_frame), 1);
        check("t4_len", 32'(pkt_len), 2);
        idle();
        check("t4_done1", 32'(chk_done), 1);
        check("t4_pass1", 32'(chk_pass), 1);
        idle();
        beat(1, 0, 0, 99, 0, 0);
        check("t5_nodone", 32'(chk_done), 0);
        check("t5_ecnt", 32'(err_count), 3);
        for (int i = 0; i < 257; i++) beat(1, i == 0, i == 256, 16'(i), 256, 32896);
        check("t6_errlen", 32'(chk_err_len), 1);
        check("t6_len", 32'(pkt_len), 256);
        for (int i = 0; i < 256; i++) beat(1, i == 0, i == 255, 16'(i), 256, 32640);
        check("t6_pass256", 32'(chk_pass), 1);
        beat(1, 1, 0, 1, 4, 10); beat(1, 0, 0, 2, 0, 0); beat(1, 0, 0, 3, 0, 0);
        do_reset();
        idle();
        check("t7_nodone", 32'(chk_done), 0);
        beat(1, 1, 0, 2, 2, 4); beat(1, 0, 1, 2, 0, 0);
        check("t7_pass", 32'(chk_pass), 1);
        check("t7_pcnt", 32'(pkt_count), 1);
        for (int p = 0; p < 150; p++) begin
            int L = $urandom_range(1, 10);
            int val = $urandom_range(0, 1000);
            int s = 0;
            bit drop = $urandom_range(0, 7) == 0;
            for (int i = 0; i < L; i++) begin
                val = ($urandom_range(0, 7) == 0) ? val - $urandom_range(1, 50) : val + $urandom_range(0, 40);
                if (val < 0) val = 0;
                vals[i] = val;
                s += val;
            end
            if ($urandom_range(0, 4) == 0) L = L;
            if ($urandom_range(0, 9) == 0) beat(1, 0, 0, 16'($urandom), 0, 0);
            for (int i = 0; i < L; i++) begin
                if ($urandom_range(0, 3) == 0) beat(0, 1'($urandom), 1'($urandom), 16'($urandom), 0, 0);
                beat(1, i == 0, i == L - 1 && !drop, 16'(vals[i]),
                     9'(($urandom_range(0, 4) == 0) ? L + 1 : L),
                     25'(($urandom_range(0, 4) == 0) ? s + 3 : s));
            end
        end
        beat(1, 1, 1, 0, 1, 0);
        idle(); idle(); idle();
        check("end_pcnt", 32'(pkt_count), 32'(m_pkt));
        check("end_ecnt", 32'(err_count), 32'(m_err));
        check("end_pending", 32'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
